mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be exactly:
- clock_i  in  1  sole clock; all state updates on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  request a new operation; sampled only in IDLE.
- op_i  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i.
- src_a_i  in  32  multiplicand / dividend; sampled with start_i.
- src_b_i  in  32  multiplier / divisor; sampled with start_i.
- cancel_i  in  1  pipeline flush; aborts the current operation.
- busy_o  out  1  high whenever state is not IDLE.
- done_o  out  1  one-cycle completion pulse.
- hi_write_enable_o  out  1  HI register write strobe.
- hi_write_data_o  out  32  HI write value.
- lo_write_enable_o  out  1  LO register write strobe.
- lo_write_data_o  out  32  LO write value.

Function
REQ-003 The FSM SHALL have states IDLE, MUL, DIV and DONE.
REQ-004 In IDLE, start_i=1 with cancel_i=0 in cycle T SHALL latch operands and op and enter MUL (op 0x) or DIV (op 1x) at T+1; otherwise the FSM SHALL stay in IDLE.
REQ-005 start_i outside IDLE SHALL be ignored; the operands are not re-sampled.
REQ-006 Signed ops SHALL take magnitudes of the operands, iterate unsigned, then fix signs: product and quotient negative iff sign(a) xor sign(b); remainder takes the sign of a.
REQ-007 Iterative multiply (shift-add) and divide (radix-2 restoring) SHALL each spend exactly 32 cycles (T+1..T+32) in MUL/DIV, then enter DONE at T+33.
REQ-008 In DONE, done_o, hi_write_enable_o and lo_write_enable_o SHALL all be 1 for exactly one cycle, and the FSM SHALL return to IDLE next cycle.
REQ-009 Multiply results SHALL be HI = product[63:32] and LO = product[31:0]; divide results SHALL be HI = remainder and LO = quotient.
REQ-010 Divide by zero SHALL complete with normal latency and give HI = src_a_i and LO = 32'hFFFFFFFF for both DIV and DIVU.
REQ-011 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give LO = 32'h80000000 and HI = 0.
REQ-012 Outside DONE, both write enables SHALL be 0 and both write-data outputs SHALL be 0.
REQ-013 cancel_i=1 in MUL, DIV or DONE SHALL force IDLE next cycle. If cancel_i is asserted in DONE, the write strobes and done_o in that cycle SHALL be suppressed.
REQ-014 cancel_i and start_i both high in IDLE SHALL leave the FSM in IDLE.
REQ-015 busy_o SHALL be derived combinationally from the state.
REQ-016 A new start SHALL be accepted in the IDLE cycle immediately after DONE, giving back-to-back throughput of one operation per latency+1 cycles.

Reset
REQ-017 When reset_i=1 at a clock edge, the FSM SHALL go to IDLE and all internal registers SHALL clear to 0, regardless of state.
REQ-018 After reset, every output SHALL be 0.
REQ-019 Reset during an operation SHALL abort it with no HI/LO write.

Configuration
REQ-020 The macro MDU_FAST_MUL_EN SHALL select multiply behaviour.
- Defined: multiply is single-cycle using a 33x33 signed product. MUL lasts one cycle (T+1), DONE is at T+2, and busy_o is high T+1..T+2.
- Undefined: multiply is iterative per REQ-007.
- Divide behaviour SHALL be identical in both builds.

Verification
REQ-021 MULTU, a=32'hFFFFFFFF, b=32'h2 -> at DONE, HI=1 and LO=32'hFFFFFFFE. done_o is at T+33, or at T+2 with MDU_FAST_MUL_EN.
REQ-022 DIV, a=-7 (32'hFFFFFFF9), b=2 -> at T+33, LO=32'hFFFFFFFD and HI=32'hFFFFFFFF.
REQ-023 DIVU, a=100, b=0 -> at T+33, HI=100 and LO=32'hFFFFFFFF.
REQ-024 DIV started, then cancel_i pulsed at T+10 -> IDLE at T+11; no write strobe ever appears; a new start at T+11 is accepted.
REQ-025 MULT, a=-3, b=5, with start_i re-asserted at T+5 with different operands -> at DONE, HI=32'hFFFFFFFF and LO=32'hFFFFFFF1; the second start is ignored.
REQ-026 DIVU started, then reset_i at T+20 -> all outputs 0 at T+21 and no write strobe.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit writing HI/LO on completion.
// Define MDU_FAST_MUL_EN for a single-cycle multiplier; divide is always iterative.
module mul_div_unit (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        cancel_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        hi_write_enable_o,
  output logic [31:0] hi_write_data_o,
  output logic        lo_write_enable_o,
  output logic [31:0] lo_write_data_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // MUL   | multiplying (32 shift-add steps, or one cycle in the fast build)
  // DIV   | 32 restoring divide steps
  // DONE  | one-cycle HI/LO write
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic [4:0]  count;
  logic [63:0] acc;      // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [31:0] opnd;     // multiplicand or divisor magnitude
  logic [31:0] a_raw;
  logic        op_div;
  logic        neg_res;
  logic        neg_rem;
  logic        div_zero;

  logic        signed_op;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        write_fire;

  assign signed_op = ~op_i[0];
  assign mag_a     = (signed_op && src_a_i[31]) ? -src_a_i : src_a_i;
  assign mag_b     = (signed_op && src_b_i[31]) ? -src_b_i : src_b_i;
  assign div_shift = {acc[63:32], acc[31]};
  assign div_diff  = div_shift - {1'b0, opnd};

`ifdef MDU_FAST_MUL_EN
  logic [31:0]        b_raw;
  logic               is_unsigned;
  logic signed [32:0] fast_a;
  logic signed [32:0] fast_b;
  logic signed [63:0] fast_prod;

  assign fast_a    = {~is_unsigned & a_raw[31], a_raw};
  assign fast_b    = {~is_unsigned & b_raw[31], b_raw};
  assign fast_prod = 64'(fast_a) * 64'(fast_b);
`else
  logic [32:0] mul_sum;
  logic [63:0] prod_fix;

  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign prod_fix = neg_res ? -acc : acc;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state    <= S_IDLE;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      op_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
`ifdef MDU_FAST_MUL_EN
      b_raw       <= '0;
      is_unsigned <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i && !cancel_i) begin
            a_raw    <= src_a_i;
            op_div   <= op_i[1];
            neg_res  <= signed_op & (src_a_i[31] ^ src_b_i[31]);
            neg_rem  <= signed_op & src_a_i[31];
            div_zero <= (src_b_i == 32'd0);
            count    <= 5'd31;
`ifdef MDU_FAST_MUL_EN
            b_raw       <= src_b_i;
            is_unsigned <= op_i[0];
`endif
            if (op_i[1]) begin
              opnd  <= mag_b;
              acc   <= {32'd0, mag_a};
              state <= S_DIV;
            end else begin
              opnd  <= mag_a;
              acc   <= {32'd0, mag_b};
              state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          if (cancel_i) begin
            state <= S_IDLE;
          end else begin
`ifdef MDU_FAST_MUL_EN
            acc   <= fast_prod;
            state <= S_DONE;
`else
            acc   <= {mul_sum, acc[31:1]};
            count <= count - 5'd1;
            if (count == 5'd0) state <= S_DONE;
`endif
          end
        end
        S_DIV: begin
          if (cancel_i) begin
            state <= S_IDLE;
          end else begin
            if (!div_diff[32]) acc <= {div_diff[31:0], acc[30:0], 1'b1};
            else               acc <= {div_shift[31:0], acc[30:0], 1'b0};
            count <= count - 5'd1;
            if (count == 5'd0) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (op_div) begin
      if (div_zero) begin
        res_hi = a_raw;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = neg_rem ? -acc[63:32] : acc[63:32];
        res_lo = neg_res ? -acc[31:0]  : acc[31:0];
      end
    end else begin
`ifdef MDU_FAST_MUL_EN
      {res_hi, res_lo} = acc;
`else
      {res_hi, res_lo} = prod_fix;
`endif
    end
  end

  // A cancel arriving in DONE suppresses the write entirely.
  assign write_fire        = (state == S_DONE) && !cancel_i;
  assign busy_o            = (state != S_IDLE);
  assign done_o            = write_fire;
  assign hi_write_enable_o = write_fire;
  assign lo_write_enable_o = write_fire;
  assign hi_write_data_o   = write_fire ? res_hi : 32'd0;
  assign lo_write_data_o   = write_fire ? res_lo : 32'd0;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed ops push expected HI/LO and done cycle.
module tb_mul_div_unit;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT    = 2;
  localparam int RESTART_AT = 1;
`else
  localparam int MUL_LAT    = 33;
  localparam int RESTART_AT = 5;
`endif
  localparam int DIV_LAT = 33;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        cancel_i;
  logic        busy_o;
  logic        done_o;
  logic        hi_write_enable_o;
  logic [31:0] hi_write_data_o;
  logic        lo_write_enable_o;
  logic [31:0] lo_write_data_o;

  mul_div_unit dut (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .start_i(start_i),
    .op_i(op_i),
    .src_a_i(src_a_i),
    .src_b_i(src_b_i),
    .cancel_i(cancel_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .hi_write_enable_o(hi_write_enable_o),
    .hi_write_data_o(hi_write_data_o),
    .lo_write_enable_o(lo_write_enable_o),
    .lo_write_data_o(lo_write_data_o)
  );

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          at;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse; strobes/data must be quiet otherwise.
  exp_t e;
  always @(negedge clock_i) begin
    if (done_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done_o high at cycle %0d with nothing expected", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.at);
        chk("hi_data", hi_write_data_o, e.hi);
        chk("lo_data", lo_write_data_o, e.lo);
        chk("hi_we", {31'd0, hi_write_enable_o}, 32'd1);
        chk("lo_we", {31'd0, lo_write_enable_o}, 32'd1);
      end
    end else begin
      chk("quiet_strobes", {30'd0, hi_write_enable_o, lo_write_enable_o}, 32'd0);
      chk("quiet_data", hi_write_data_o | lo_write_data_o, 32'd0);
      if (sb.size() != 0 && cyc > sb[0].at) begin
        checks++;
        errors++;
        $display("FAIL late_done: no done_o at cycle %0d, required at %0d", cyc, sb[0].at);
        void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo);
    int lat;
    int t0;
    lat = op[1] ? DIV_LAT : MUL_LAT;
    start_i = 1'b1;
    op_i    = op;
    src_a_i = a;
    src_b_i = b;
    t0      = cyc;
    sb.push_back('{hi, lo, t0 + lat});
    step();
    start_i = 1'b0;
    src_a_i = 32'hDEAD_BEEF;
    src_b_i = 32'h0BAD_F00D;
    chk("busy_running", {31'd0, busy_o}, 32'd1);
    while (cyc < t0 + lat + 1) step();
    chk("busy_after_done", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    int t0;
    reset_i  = 1'b1;
    start_i  = 1'b0;
    cancel_i = 1'b0;
    op_i     = 2'b00;
    src_a_i  = 32'd0;
    src_b_i  = 32'd0;
    repeat (3) step();
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_hi_data", hi_write_data_o, 32'd0);
    chk("rst_lo_data", lo_write_data_o, 32'd0);
    reset_i = 1'b0;
    step();

    // Start with cancel_i high must be refused.
    start_i  = 1'b1;
    cancel_i = 1'b1;
    op_i     = 2'b10;
    src_a_i  = 32'd5;
    src_b_i  = 32'd1;
    step();
    start_i  = 1'b0;
    cancel_i = 1'b0;
    chk("start_cancel_idle", {31'd0, busy_o}, 32'd0);

    run_op(2'b01, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999);
    run_op(2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    run_op(2'b01, 32'h1234_5678, 32'h10,        32'h1,         32'h2345_6780);

    // MULT -3*5 with a second start mid-operation that must be ignored.
    start_i = 1'b1;
    op_i    = 2'b00;
    src_a_i = 32'hFFFF_FFFD;
    src_b_i = 32'd5;
    t0      = cyc;
    sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFF1, t0 + MUL_LAT});
    step();
    start_i = 1'b0;
    while (cyc < t0 + RESTART_AT) step();
    start_i = 1'b1;
    op_i    = 2'b11;
    src_a_i = 32'd77;
    src_b_i = 32'd3;
    step();
    start_i = 1'b0;
    while (cyc < t0 + MUL_LAT + 1) step();
    chk("restart_ignored_idle", {31'd0, busy_o}, 32'd0);

    // DIV cancelled at T+10, new op accepted at T+11.
    start_i = 1'b1;
    op_i    = 2'b10;
    src_a_i = 32'd50;
    src_b_i = 32'd3;
    t0      = cyc;
    step();
    start_i = 1'b0;
    while (cyc < t0 + 10) step();
    cancel_i = 1'b1;
    step();
    cancel_i = 1'b0;
    chk("cancel_idle_cycle", cyc, t0 + 11);
    chk("cancel_idle_busy", {31'd0, busy_o}, 32'd0);
    run_op(2'b11, 32'd9, 32'd4, 32'd1, 32'd2);

    // Cancel landing on the DONE cycle suppresses the write.
    start_i = 1'b1;
    op_i    = 2'b01;
    src_a_i = 32'd6;
    src_b_i = 32'd7;
    t0      = cyc;
    step();
    start_i = 1'b0;
    while (cyc < t0 + MUL_LAT) step();
    cancel_i = 1'b1;
    #1;
    chk("done_cancel_done", {31'd0, done_o}, 32'd0);
    chk("done_cancel_we", {31'd0, hi_write_enable_o | lo_write_enable_o}, 32'd0);
    step();
    cancel_i = 1'b0;
    chk("done_cancel_idle", {31'd0, busy_o}, 32'd0);

    // Reset in the middle of a DIVU.
    start_i = 1'b1;
    op_i    = 2'b11;
    src_a_i = 32'd1000;
    src_b_i = 32'd7;
    t0      = cyc;
    step();
    start_i = 1'b0;
    while (cyc < t0 + 20) step();
    reset_i = 1'b1;
    step();
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_done", {31'd0, done_o}, 32'd0);
    chk("midrst_we", {31'd0, hi_write_enable_o | lo_write_enable_o}, 32'd0);
    chk("midrst_data", hi_write_data_o | lo_write_data_o, 32'd0);
    reset_i = 1'b0;
    repeat (40) step();

    run_op(2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'd15);

    repeat (3) step();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
